// File: rtl/exu_alu_iq.sv
// ---------------------------------------------------------------------------
// mercury_pkg / exu_alu_iq
//
// Purpose: ALU issue queue for the execute unit. Holds up to DEPTH dispatched
// ALU micro-ops in age order (index 0 oldest), wakes waiting sources from the
// local s1 writeback and an external writeback bus, issues the oldest ready
// entry to the combinational ALU (s0) and registers its result into the s1
// writeback stage.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     drop all queued entries and the s1 result
//   enq_*                     dispatch handshake and micro-op fields
//   wb_ext_valid/tag/data     writeback from another execute unit
//   s0_valid/alu_op/operandA/B  issue to the ALU (combinational from state)
//   s0_alu_result             ALU result for the current s0 operands
//   s1_wb_valid/tag/data      registered writeback (also local wakeup bus)
// ---------------------------------------------------------------------------
package mercury_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_t;
endpackage

module exu_alu_iq
  import mercury_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  alu_op_t          enq_alu_op,
  input  logic [TAG_W-1:0] enq_dst_tag,
  input  logic             enq_srcA_rdy,
  input  logic             enq_srcB_rdy,
  input  logic [TAG_W-1:0] enq_srcA_tag,
  input  logic [TAG_W-1:0] enq_srcB_tag,
  input  logic [63:0]      enq_srcA_data,
  input  logic [63:0]      enq_srcB_data,
  input  logic             wb_ext_valid,
  input  logic [TAG_W-1:0] wb_ext_tag,
  input  logic [63:0]      wb_ext_data,
  output logic             s0_valid,
  output alu_op_t          s0_alu_op,
  output logic [63:0]      s0_alu_operandA,
  output logic [63:0]      s0_alu_operandB,
  input  logic [63:0]      s0_alu_result,
  output logic             s1_wb_valid,
  output logic [TAG_W-1:0] s1_wb_tag,
  output logic [63:0]      s1_wb_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } src_t;

  typedef struct packed {
    logic             vld;
    alu_op_t          op;
    logic [TAG_W-1:0] dst;
    src_t             a;
    src_t             b;
  } ent_t;

  ent_t             r_q [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_s1_valid;
  logic [TAG_W-1:0] r_s1_tag;
  logic [63:0]      r_s1_data;

  logic             w_sel_found;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_issue;
  logic             w_enq_fire;
  logic [CNT_W-1:0] w_enq_idx;
  logic [CNT_W-1:0] w_count_nxt;
  ent_t             w_enq_ent;
  ent_t             w_wk   [DEPTH];
  ent_t             w_up   [DEPTH];
  ent_t             w_nxt  [DEPTH];

  // A waiting source captures the matching bus value; the local s1 bus has
  // priority over the external bus when both carry the same tag.
  function automatic src_t wake(input src_t s,
                                input logic s1_v, input logic [TAG_W-1:0] s1_t,
                                input logic [63:0] s1_d,
                                input logic x_v, input logic [TAG_W-1:0] x_t,
                                input logic [63:0] x_d);
    src_t o;
    o = s;
    if (!s.rdy && s1_v && (s.tag == s1_t)) begin
      o.rdy  = 1'b1;
      o.data = s1_d;
    end else if (!s.rdy && x_v && (s.tag == x_t)) begin
      o.rdy  = 1'b1;
      o.data = x_d;
    end else begin
      o = s;
    end
    return o;
  endfunction

  assign enq_ready   = (r_count < DEPTH_C) & ~rst & ~flush;
  assign w_enq_fire  = enq_valid & enq_ready;
  assign s1_wb_valid = r_s1_valid;
  assign s1_wb_tag   = r_s1_tag;
  assign s1_wb_data  = r_s1_data;

  // Oldest-ready select; rdy bits are registered, so a source woken this
  // cycle only becomes selectable on the next one.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_q[i].vld && r_q[i].a.rdy && r_q[i].b.rdy) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end else begin
        w_sel_found = w_sel_found;
      end
    end
    w_issue = w_sel_found & ~rst & ~flush;
  end

  // Drive the ALU from the selected entry, zeros when idle.
  always_comb begin
    s0_valid        = w_issue;
    s0_alu_op       = ALU_ADD;
    s0_alu_operandA = 64'd0;
    s0_alu_operandB = 64'd0;
    if (w_issue) begin
      s0_alu_op       = r_q[w_sel_idx].op;
      s0_alu_operandA = r_q[w_sel_idx].a.data;
      s0_alu_operandB = r_q[w_sel_idx].b.data;
    end else begin
      s0_alu_op       = ALU_ADD;
    end
  end

  // Next queue image: wakeup, collapse over the issued slot, then append.
  always_comb begin
    w_enq_ent.vld = 1'b1;
    w_enq_ent.op  = enq_alu_op;
    w_enq_ent.dst = enq_dst_tag;
    w_enq_ent.a   = wake('{enq_srcA_rdy, enq_srcA_tag, enq_srcA_data},
                         r_s1_valid, r_s1_tag, r_s1_data,
                         wb_ext_valid, wb_ext_tag, wb_ext_data);
    w_enq_ent.b   = wake('{enq_srcB_rdy, enq_srcB_tag, enq_srcB_data},
                         r_s1_valid, r_s1_tag, r_s1_data,
                         wb_ext_valid, wb_ext_tag, wb_ext_data);
    // Space freed by an issue is reused by the append in the same cycle.
    w_enq_idx   = r_count - CNT_W'(w_issue);
    w_count_nxt = r_count + CNT_W'(w_enq_fire) - CNT_W'(w_issue);
    for (int i = 0; i < DEPTH; i++) begin
      w_wk[i]   = r_q[i];
      w_wk[i].a = wake(r_q[i].a, r_s1_valid, r_s1_tag, r_s1_data,
                       wb_ext_valid, wb_ext_tag, wb_ext_data);
      w_wk[i].b = wake(r_q[i].b, r_s1_valid, r_s1_tag, r_s1_data,
                       wb_ext_valid, wb_ext_tag, wb_ext_data);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_up[i] = w_wk[i + 1];
    end
    w_up[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_issue && (IDX_W'(i) >= w_sel_idx)) begin
        w_nxt[i] = w_up[i];
      end else begin
        w_nxt[i] = w_wk[i];
      end
      if (w_enq_fire && (CNT_W'(i) == w_enq_idx)) begin
        w_nxt[i] = w_enq_ent;
      end else begin
        w_nxt[i] = w_nxt[i];
      end
    end
  end

  // Queue storage and occupancy count.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i].vld <= 1'b0;
      end
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= w_nxt[i];
      end
      r_count <= w_count_nxt;
    end
  end

  // s1 writeback stage; tag/data hold while nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_data  <= 64'd0;
    end else begin
      r_s1_valid <= w_issue & ~flush;
      if (w_issue) begin
        r_s1_tag  <= r_q[w_sel_idx].dst;
        r_s1_data <= s0_alu_result;
      end else begin
        r_s1_tag  <= r_s1_tag;
        r_s1_data <= r_s1_data;
      end
    end
  end

endmodule

// File: doc/exu_alu_iq.md
# exu_alu_iq

ALU issue queue for the execute unit: buffers up to DEPTH dispatched ALU micro-ops, tracks source-operand readiness via tag wakeup, and issues the oldest ready entry each cycle to the combinational `exu_alu` stage (s0). It registers the ALU result into an s1 writeback stage. That stage drives the register-file write and wakes up dependent entries inside the queue.

## Interface
- DEPTH, 4, number of queue entries (≥2)
- TAG_W, 6, physical register tag width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all queued entries and the s1 result
- enq_valid  in  1  dispatch offers a micro-op
- enq_ready  out  1  queue can accept; transfer when enq_valid & enq_ready
- enq_alu_op  in  alu_op_t  operation (mercury_pkg)
- enq_dst_tag  in  TAG_W  destination tag
- enq_srcA_rdy / enq_srcB_rdy  in  1 each  source value already valid
- enq_srcA_tag / enq_srcB_tag  in  TAG_W each  source tag when not ready
- enq_srcA_data / enq_srcB_data  in  64 each  source value when ready
- wb_ext_valid  in  1  writeback from another execute unit
- wb_ext_tag  in  TAG_W, wb_ext_data  in  64
- s0_valid  out  1  issue to ALU this cycle
- s0_alu_op  out  alu_op_t; s0_alu_operandA / s0_alu_operandB  out  64
- s0_alu_result  in  64  combinational ALU result for the current s0 operands
- s1_wb_valid  out  1; s1_wb_tag  out  TAG_W; s1_wb_data  out  64  registered writeback

## Operation
- Collapsing queue. Index 0 is the oldest entry. Each entry holds valid, op, dst_tag, and per-source {rdy, tag, data}.
- Select: the lowest-index valid entry with both sources rdy. s0_valid=1 and s0 outputs come from that entry, combinationally from state. With no candidate, s0_valid=0 and op/operands drive 0.
- Issued entry is removed at the clock edge. Younger entries shift down by one. Order is preserved.
- s1: on each edge, s1_wb_valid<=s0_valid & ~flush, s1_wb_tag<=selected dst_tag, s1_wb_data<=s0_alu_result. Tag/data hold their value when s0_valid=0.
- Wakeup sources: s1 writeback (s1_wb_valid/tag/data) and wb_ext. For every valid entry and each non-ready source, a tag match sets rdy and captures data at the edge. If both buses match the same tag, s1 data wins.
- A woken entry is not selectable in the wakeup cycle. It becomes selectable the next cycle.
- Enqueue snoop: an incoming non-ready source that matches a wakeup bus in the enqueue cycle is written as rdy with the bus data.
- enq_ready = (count < DEPTH) & ~rst & ~flush. It depends only on registered count; a same-cycle issue does not free space for enqueue.
- Simultaneous enqueue and issue: the new entry is written at index count-1, after compaction. Without an issue it is written at index count.
- flush: all entry valids clear and s1_wb_valid<=0 at the edge. s0_valid is forced 0 and enqueue is ignored in the flush cycle.
- rst: same as flush, plus count<=0, s1_wb_tag<=0, s1_wb_data<=0. It overrides everything, including mid-operation.

## Timing
- Issue latency: an entry enqueued with both sources ready at edge t is selectable in cycle t+1.
- Result: issue in cycle c gives s1_wb_valid/data in cycle c+1.
- Dependent chain: a consumer waiting on a producer issued in cycle c is woken at the end of c+1 and issues in c+2. The sustained dependent-chain rate is one op per 2 cycles.
- Independent ready ops issue one per cycle. At most one issue per cycle.
- Reset values: s0_valid=0, s0 op/operands=0, s1_wb_valid=0, s1_wb_tag=0, s1_wb_data=0, enq_ready=0 while rst=1 and 1 on the first cycle after.
- Full: count=DEPTH → enq_ready=0 for that cycle even when an issue occurs in the same cycle.

## Test plan
- Reset, then enqueue ADD A=5 B=7 dst=3, both ready → s0_valid in the next cycle with operands 5/7; the following cycle s1_wb_valid=1, tag=3, data=12.
- Enqueue op1 dst=4 (A=1, B=2, ready), then op2 with A waiting on tag 4 and B=10 ready → op2 issues exactly 2 cycles after op1, with operandA=3 and operandB=10.
- Fill 4 entries with sources pending on tag 9 → enq_ready=0. Pulse wb_ext tag=9 data=0x55 → all four issue in age order on consecutive cycles, each with operandA=0x55.
- Enqueue a non-ready source for tag 7 in the same cycle wb_ext_valid tag=7 data=0xAB → the entry issues next cycle with 0xAB.
- With 3 entries queued and one issuing, assert flush → next cycle s1_wb_valid=0, count=0, enq_ready=1. No issue occurs in the flush cycle.
- Assert rst while a dependent chain is in flight → all outputs reach their reset values and no stale wakeup is captured after reset.
